// File: rtl/usb_player_pkg.sv
// Shared constants for the USB sample player: state encoding and
// word/rate limits used by the player and its testbench.
package usb_player_pkg;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [15:0] MIN_RATE_DIV   = 16'd1;

    typedef logic [1:0] player_state_t;

    localparam player_state_t ST_IDLE  = 2'd0;
    localparam player_state_t ST_PRIME = 2'd1;
    localparam player_state_t ST_PLAY  = 2'd2;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous word FIFO with registered count/full, a one-cycle read
// latency and a flush that empties the queue while still taking a write.
module sample_fifo #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             wr_ok, rd_ok;

    // Pointer, count and read-data next-state
    always_comb begin
        wr_ok     = wr_en && (count_q < CW'(DEPTH));
        rd_ok     = rd_en && (count_q != {CW{1'b0}}) && !flush;
        wr_ptr_d  = wr_ptr_q + AW'(wr_ok);
        rd_data_d = rd_data_q;
        if (rd_ok) begin
            rd_data_d = mem_q[rd_ptr_q];
        end else begin
            rd_data_d = rd_data_q;
        end
        // A flush leaves at most the word written in the same cycle.
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = CW'(wr_ok);
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(rd_ok);
            count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
        end
        full_d = (count_d == CW'(DEPTH));
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= {CW{1'b0}};
            full_q    <= 1'b0;
            rd_data_q <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = (count_q == {CW{1'b0}});

endmodule

// File: rtl/usb_sample_player.sv
// Buffers 32-bit USB sample words and plays them out byte by byte as signed
// 8-bit samples at a programmable rate, with prime/underrun/overflow handling.
module usb_sample_player
    import usb_player_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                usb_rd_data,
    input  logic                       usb_rd_data_valid,
    output logic                       usb_rd_full,
    input  logic                       enable,
    input  logic [15:0]                rate_div,
    input  logic [$clog2(DEPTH):0]     prime_level,
    input  logic                       counters_clear,
    output logic signed [7:0]          out,
    output logic                       out_valid,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [1:0]                 state,
    output logic [CNT_WIDTH-1:0]       underrun_count,
    output logic [CNT_WIDTH-1:0]       overflow_count
);
    localparam int         CW       = $clog2(DEPTH) + 1;
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic inc);
        if (inc && (v != {CNT_WIDTH{1'b1}})) begin
            sat_inc = v + CNT_WIDTH'(1);
        end else begin
            sat_inc = v;
        end
    endfunction

    player_state_t        state_q, state_d;
    logic signed [7:0]    out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic [31:0]          hold_data_q, hold_data_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [1:0]           idx_q, idx_d;
    logic                 rd_pending_q, rd_pending_d;
    logic [15:0]          rate_cnt_q, rate_cnt_d;
    logic [CNT_WIDTH-1:0] underrun_q, underrun_d;
    logic [CNT_WIDTH-1:0] overflow_q, overflow_d;

    logic [31:0]   fifo_rd_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty, fifo_flush, fifo_rd_en;
    logic [15:0]   reload;
    logic          strobe, consume, underrun_ev, primed;
    logic [CW:0]   avail, prime_need;

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (fifo_flush),
        .wr_en   (usb_rd_data_valid),
        .wr_data (usb_rd_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Strobe, prefetch and priming decisions
    always_comb begin
        reload      = (rate_div < MIN_RATE_DIV) ? MIN_RATE_DIV : rate_div;
        strobe      = (state_q == ST_PLAY) && (rate_cnt_q == 16'd0);
        consume     = strobe && hold_valid_q && enable;
        underrun_ev = strobe && !hold_valid_q && enable;
        // Dropping enable empties the queue once; words keep collecting while idle.
        fifo_flush  = (state_q != ST_IDLE) && !enable;
        fifo_rd_en  = enable && (state_q != ST_IDLE) && !rd_pending_q && !fifo_empty &&
                      (!hold_valid_q || (consume && (idx_q == LAST_IDX)));
        avail       = {1'b0, fifo_count} + {{CW{1'b0}}, hold_valid_q};
        prime_need  = (prime_level == {CW{1'b0}}) ? {{CW{1'b0}}, 1'b1} : {1'b0, prime_level};
        primed      = (avail >= prime_need);
    end

    // Rate counter
    always_comb begin
        if ((state_q != ST_PLAY) || (rate_cnt_q == 16'd0)) begin
            rate_cnt_d = reload;
        end else begin
            rate_cnt_d = rate_cnt_q - 16'd1;
        end
    end

    // Holding register and prefetch tracking
    always_comb begin
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        idx_d        = idx_q;
        rd_pending_d = fifo_rd_en;
        if (!enable || (state_q == ST_IDLE)) begin
            hold_valid_d = 1'b0;
            idx_d        = 2'd0;
        end else if (rd_pending_q) begin
            hold_data_d  = fifo_rd_data;
            hold_valid_d = 1'b1;
            idx_d        = 2'd0;
        end else if (consume) begin
            idx_d        = idx_q + 2'd1;
            hold_valid_d = (idx_q != LAST_IDX);
        end else begin
            hold_valid_d = hold_valid_q;
        end
    end

    // Player state and sample output
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_PRIME;
                ST_PRIME: state_d = primed ? ST_PLAY : ST_PRIME;
                ST_PLAY:  state_d = underrun_ev ? ST_PRIME : ST_PLAY;
                default:  state_d = ST_IDLE;
            endcase
        end
        if (!enable || (state_q != ST_PLAY)) begin
            out_d = 8'sd0;
        end else if (consume) begin
            out_d       = $signed(hold_data_q[8*idx_q +: 8]);
            out_valid_d = 1'b1;
        end else if (underrun_ev) begin
            out_d       = 8'sd0;
            out_valid_d = 1'b1;
        end else begin
            out_d = out_q;
        end
    end

    // Status counters; clear wins over a coincident event
    always_comb begin
        if (counters_clear) begin
            underrun_d = {CNT_WIDTH{1'b0}};
            overflow_d = {CNT_WIDTH{1'b0}};
        end else begin
            underrun_d = sat_inc(underrun_q, underrun_ev);
            overflow_d = sat_inc(overflow_q, usb_rd_data_valid && fifo_full);
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            out_q        <= 8'sd0;
            out_valid_q  <= 1'b0;
            hold_data_q  <= 32'd0;
            hold_valid_q <= 1'b0;
            idx_q        <= 2'd0;
            rd_pending_q <= 1'b0;
            rate_cnt_q   <= 16'd0;
            underrun_q   <= {CNT_WIDTH{1'b0}};
            overflow_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            idx_q        <= idx_d;
            rd_pending_q <= rd_pending_d;
            rate_cnt_q   <= rate_cnt_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out            = out_q;
    assign out_valid      = out_valid_q;
    assign fill_level     = fifo_count;
    assign usb_rd_full    = fifo_full;
    assign state          = state_q;
    assign underrun_count = underrun_q;
    assign overflow_count = overflow_q;

endmodule

// File: tb/tb_usb_sample_player.sv
// Directed bench for usb_sample_player: expected samples are queued as words
// are written and popped whenever out_valid pulses.
module tb_usb_sample_player;
    import usb_player_pkg::*;

    localparam int DEPTH  = 1024;
    localparam int AW     = $clog2(DEPTH);
    localparam int SDEPTH = 4;
    localparam int SAW    = $clog2(SDEPTH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [31:0]   wdata;
    logic          wvalid, full, enable, counters_clear, out_valid;
    logic [15:0]   rate_div;
    logic [AW:0]   prime_level, fill;
    logic [7:0]    dut_out;
    logic [1:0]    state;
    logic [31:0]   ucnt, ocnt;

    logic [31:0]   s_wdata;
    logic          s_wvalid, s_full, s_enable, s_clear, s_out_valid;
    logic [15:0]   s_rate_div;
    logic [SAW:0]  s_prime, s_fill;
    logic [7:0]    s_out;
    logic [1:0]    s_state;
    logic [31:0]   s_ucnt, s_ocnt;

    usb_sample_player #(.DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .usb_rd_data(wdata), .usb_rd_data_valid(wvalid),
        .usb_rd_full(full), .enable(enable), .rate_div(rate_div), .prime_level(prime_level),
        .counters_clear(counters_clear), .out(dut_out), .out_valid(out_valid),
        .fill_level(fill), .state(state), .underrun_count(ucnt), .overflow_count(ocnt)
    );

    usb_sample_player #(.DEPTH(SDEPTH), .CNT_WIDTH(32)) dut_small (
        .clk(clk), .reset(reset), .usb_rd_data(s_wdata), .usb_rd_data_valid(s_wvalid),
        .usb_rd_full(s_full), .enable(s_enable), .rate_div(s_rate_div), .prime_level(s_prime),
        .counters_clear(s_clear), .out(s_out), .out_valid(s_out_valid),
        .fill_level(s_fill), .state(s_state), .underrun_count(s_ucnt), .overflow_count(s_ocnt)
    );

    logic [7:0] sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int en_cyc   = 0;
    int last_cyc = -1;
    int exp_period = 0;
    bit period_chk = 1'b0;
    bit first_chk  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_sample", out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("sample", dut_out, e);
            end
            if (first_chk) begin
                check("first_latency", cyc - en_cyc, 6);
                first_chk = 1'b0;
            end
            if (period_chk && last_cyc >= 0) check("sample_period", cyc - last_cyc, exp_period);
            last_cyc = cyc;
        end
    endtask

    task automatic put_word(input logic [31:0] w);
        wdata  = w;
        wvalid = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(w[8*i +: 8]);
        tick();
        wvalid = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic wait_left(input string tag, input int left, input int budget);
        int n;
        n = 0;
        while (sb.size() > left && n < budget) begin
            tick();
            n++;
        end
        check(tag, sb.size(), left);
    endtask

    initial begin
        reset = 1'b1; wdata = 32'd0; wvalid = 1'b0; enable = 1'b0; counters_clear = 1'b0;
        rate_div = 16'd3; prime_level = 11'd2;
        s_wdata = 32'd0; s_wvalid = 1'b0; s_enable = 1'b0; s_clear = 1'b0;
        s_rate_div = 16'd1; s_prime = 3'd1;
        tick(); tick();
        check("rst_out", dut_out, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_fill", fill, 0);
        check("rst_full", full, 1'b0);
        check("rst_state", state, ST_IDLE);
        check("rst_ucnt", ucnt, 0);
        check("rst_ocnt", ocnt, 0);
        reset = 1'b0;
        tick();

        // Basic playback
        put_word(32'h04030201);
        put_word(32'h08070605);
        check("basic_fill", fill, 2);
        enable = 1'b1; en_cyc = cyc; first_chk = 1'b1;
        period_chk = 1'b1; exp_period = 4; last_cyc = -1;
        drain("basic_drain", 100);
        enable = 1'b0;
        tick();
        check("basic_ucnt", ucnt, 0);
        check("basic_idle", state, ST_IDLE);

        // Minimum rate, continuous stream
        rate_div = 16'd0; prime_level = 11'd4;
        enable = 1'b1; exp_period = 2; last_cyc = -1;
        tick();
        for (int i = 0; i < 64; i++) put_word($urandom);
        drain("minrate_drain", 700);
        enable = 1'b0;
        tick();
        check("minrate_ucnt", ucnt, 0);

        // Underrun then resume
        rate_div = 16'd1; prime_level = 11'd1; last_cyc = -1;
        put_word(32'h8C7B6A59);
        sb.push_back(8'h00);
        enable = 1'b1;
        drain("underrun_drain", 60);
        check("underrun_ucnt", ucnt, 1);
        check("underrun_state", state, ST_PRIME);
        check("underrun_out", dut_out, 8'h00);
        period_chk = 1'b0;
        put_word(32'hF1E2D3C4);
        drain("resume_drain", 60);
        check("resume_state", state, ST_PLAY);
        enable = 1'b0;
        tick();

        // Disable with words buffered
        rate_div = 16'd3; prime_level = 11'd2;
        for (int i = 0; i < 10; i++) put_word(32'h11111111 * (i + 1));
        check("disable_fill_before", fill, 10);
        enable = 1'b1; period_chk = 1'b1; exp_period = 4; last_cyc = -1;
        wait_left("disable_wait", 38, 80);
        enable = 1'b0;
        tick();
        sb.delete();
        check("disable_state", state, ST_IDLE);
        check("disable_fill", fill, 0);
        check("disable_out", dut_out, 8'h00);

        // Disable coinciding with an underrun strobe
        rate_div = 16'd1; prime_level = 11'd1; exp_period = 2; last_cyc = -1;
        put_word(32'h7F80FF01);
        enable = 1'b1;
        drain("dis_ur_drain", 60);
        tick();
        enable = 1'b0;
        tick();
        check("dis_ur_ucnt", ucnt, 1);
        check("dis_ur_state", state, ST_IDLE);

        // Reset during playback
        rate_div = 16'd3; prime_level = 11'd1; period_chk = 1'b0;
        put_word(32'h44332211);
        put_word(32'h88776655);
        put_word(32'hCCBBAA99);
        enable = 1'b1;
        wait_left("reset_wait", 10, 80);
        reset = 1'b1;
        tick();
        check("midrst_out", dut_out, 8'h00);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_fill", fill, 0);
        check("midrst_state", state, ST_IDLE);
        check("midrst_ucnt", ucnt, 0);
        reset = 1'b0; enable = 1'b0;
        sb.delete();
        tick();

        // Overflow on the 4-deep instance
        for (int i = 0; i < 6; i++) begin
            s_wdata = 32'hA0 + i; s_wvalid = 1'b1;
            tick();
            check("small_full", s_full, (i >= 3));
        end
        s_wvalid = 1'b0;
        check("small_ocnt", s_ocnt, 2);
        check("small_fill", s_fill, 4);
        s_wvalid = 1'b1; s_clear = 1'b1;
        tick();
        s_wvalid = 1'b0; s_clear = 1'b0;
        check("clear_priority", s_ocnt, 0);
        check("clear_fill", s_fill, 4);
        s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        check("ocnt_after_clear", s_ocnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
